// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS32 instruction fetch stage: PC, imem req/ack, held instruction to decode
// Owns the PC, applies J-type jumps locally and honours branch redirects from execute.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic [5:0]  opCode,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        drop_q, drop_d;
  logic [31:0] pc4;
  logic [31:0] redirect_tgt;

  assign pc4          = pc_q + 32'd4;
  assign redirect_tgt = redirectPc & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      hold_addr_q   <= 32'h0;
      instr_valid_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      hold_addr_q   <= hold_addr_d;
      instr_valid_q <= instr_valid_d;
      drop_q        <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imemAck && !drop_q && !redirect) state_d = S_HOLD;
      S_HOLD:  if (redirect || (instr_valid_q && instrReady)) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    hold_addr_d   = hold_addr_q;
    instr_valid_d = instr_valid_q;
    drop_d        = drop_q;

    if (state_q == S_FETCH && imemAck) begin
      drop_d = 1'b0;
      if (!drop_q && !redirect) begin
        instr_d       = imemData;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
        if (imemData[31:26] == 6'd2)
          pc_d = {pc4[31:28], imemData[25:0], 2'b00};
        else
          pc_d = pc4;
      end
    end

    if (state_q == S_HOLD && instr_valid_q && instrReady)
      instr_valid_d = 1'b0;

    // An in-flight request cannot be withdrawn: remember its address and drop its data.
    if (redirect) begin
      pc_d          = redirect_tgt;
      instr_valid_d = 1'b0;
      if (state_q == S_FETCH && !imemAck && !drop_q) begin
        drop_d      = 1'b1;
        hold_addr_d = pc_q;
      end
    end
  end

  always_comb begin
    imemReq    = (state_q == S_FETCH);
    imemAddr   = drop_q ? hold_addr_q : pc_q;
    instr      = instr_q;
    instrPc    = instr_pc_q;
    opCode     = instr_q[31:26];
    instrValid = instr_valid_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
// Delivered instructions are queued when acked and compared when decode sees them.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic [5:0]  opCode;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [31:0] redirectPc;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rstN(rstN),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instr(instr), .instrPc(instrPc), .opCode(opCode), .instrValid(instrValid),
    .instrReady(instrReady), .redirect(redirect), .redirectPc(redirectPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rstN = 1'b0; imemAck = 1'b0; imemData = 32'h0; instrReady = 1'b0;
    redirect = 1'b0; redirectPc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imemReq); end
    n_cmp++; if (instrValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instrValid); end
    n_cmp++; if (instr !== 32'h0 || instrPc !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instrPc); end
    n_cmp++; if (opCode !== 6'd0) begin n_err++; $display("FAIL reset_opcode: got %0d want 0", opCode); end
    rstN = 1'b1;
    #1;
    n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imemReq); end
    @(posedge clk); #1;
    n_cmp++; if (imemReq !== 1'b1 || imemAddr !== RST_PC) begin n_err++; $display("FAIL first_req: got %b @%h want 1 @%h", imemReq, imemAddr, RST_PC); end
    n_cmp++; if (instrValid !== 1'b0) begin n_err++; $display("FAIL first_valid: got %b want 0", instrValid); end
  endtask

  task automatic test_fetch();
    exp_t e;
    imemAck = 1'b1; imemData = 32'h2008_0005; instrReady = 1'b1;
    sb.push_back('{data: 32'h2008_0005, pc: 32'h0040_0000});
    @(posedge clk); #1;
    imemAck = 1'b0;
    n_cmp++; if (instrValid !== 1'b1 || opCode !== 6'd8) begin n_err++; $display("FAIL fetch_valid: got v=%b op=%0d want v=1 op=8", instrValid, opCode); end
    e = sb.pop_front();
    n_cmp++; if (instr !== e.data || instrPc !== e.pc) begin n_err++; $display("FAIL fetch_data: got %h@%h want %h@%h", instr, instrPc, e.data, e.pc); end
    n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", imemReq); end
    @(posedge clk); #1;
    n_cmp++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h0040_0004) begin
      n_err++; $display("FAIL next_fetch: got v=%b req=%b @%h want v=0 req=1 @00400004", instrValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    instrReady = 1'b0; imemAck = 1'b1; imemData = 32'h012A_4020;
    sb.push_back('{data: 32'h012A_4020, pc: 32'h0040_0004});
    @(posedge clk); #1;
    imemAck = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (instrValid !== 1'b1 || instr !== e.data || instrPc !== e.pc || imemReq !== 1'b0) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b %h@%h req=%b want v=1 %h@%h req=0", i, instrValid, instr, instrPc, imemReq, e.data, e.pc);
      end
      @(posedge clk); #1;
    end
    instrReady = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h0040_0008) begin
      n_err++; $display("FAIL stall_release: got v=%b req=%b @%h want v=0 req=1 @00400008", instrValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_jump();
    exp_t e;
    instrReady = 1'b1; imemAck = 1'b1; imemData = 32'h0810_0010;
    sb.push_back('{data: 32'h0810_0010, pc: 32'h0040_0008});
    @(posedge clk); #1;
    imemAck = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (instrValid !== 1'b1 || opCode !== 6'd2 || instr !== e.data || instrPc !== e.pc) begin
      n_err++; $display("FAIL jump_deliver: got v=%b op=%0d %h@%h want v=1 op=2 %h@%h", instrValid, opCode, instr, instrPc, e.data, e.pc);
    end
    @(posedge clk); #1;
    n_cmp++; if (imemReq !== 1'b1 || imemAddr !== 32'h0040_0040) begin
      n_err++; $display("FAIL jump_target: got req=%b @%h want req=1 @00400040", imemReq, imemAddr);
    end
  endtask

  task automatic test_redirect_hold();
    instrReady = 1'b0; imemAck = 1'b1; imemData = 32'h0000_0000;
    @(posedge clk); #1;
    imemAck = 1'b0;
    n_cmp++; if (instrValid !== 1'b1 || instrPc !== 32'h0040_0040) begin
      n_err++; $display("FAIL rhold_capture: got v=%b pc=%h want v=1 pc=00400040", instrValid, instrPc);
    end
    redirect = 1'b1; redirectPc = 32'h0040_000C;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_cmp++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h0040_000C) begin
      n_err++; $display("FAIL rhold_flush: got v=%b req=%b @%h want v=0 req=1 @0040000c", instrValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_redirect_drop();
    redirect = 1'b1; redirectPc = 32'h0040_0103;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (imemReq !== 1'b1 || imemAddr !== 32'h0040_000C || instrValid !== 1'b0) begin
        n_err++; $display("FAIL drop_hold[%0d]: got req=%b @%h v=%b want req=1 @0040000c v=0", i, imemReq, imemAddr, instrValid);
      end
      if (i == 2) begin imemAck = 1'b1; imemData = 32'h2008_FFFF; end
      @(posedge clk); #1;
    end
    imemAck = 1'b0;
    n_cmp++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h0040_0100) begin
      n_err++; $display("FAIL drop_refetch: got v=%b req=%b @%h want v=0 req=1 @00400100", instrValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_redirect_jump_wrap();
    exp_t e;
    imemAck = 1'b1; imemData = 32'h0800_0000; redirect = 1'b1; redirectPc = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    imemAck = 1'b0; redirect = 1'b0;
    n_cmp++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL redirect_wins: got v=%b req=%b @%h want v=0 req=1 @fffffffc", instrValid, imemReq, imemAddr);
    end
    instrReady = 1'b1; imemAck = 1'b1; imemData = 32'h3C01_1234;
    sb.push_back('{data: 32'h3C01_1234, pc: 32'hFFFF_FFFC});
    @(posedge clk); #1;
    imemAck = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (instrValid !== 1'b1 || opCode !== 6'd15 || instr !== e.data || instrPc !== e.pc) begin
      n_err++; $display("FAIL wrap_deliver: got v=%b op=%0d %h@%h want v=1 op=15 %h@%h", instrValid, opCode, instr, instrPc, e.data, e.pc);
    end
    @(posedge clk); #1;
    n_cmp++; if (imemReq !== 1'b1 || imemAddr !== 32'h0000_0000) begin
      n_err++; $display("FAIL wrap_addr: got req=%b @%h want req=1 @00000000", imemReq, imemAddr);
    end
  endtask

  task automatic test_reset_mid();
    instrReady = 1'b0; imemAck = 1'b1; imemData = 32'h2008_0001;
    @(posedge clk); #1;
    imemAck = 1'b0;
    n_cmp++; if (instrValid !== 1'b1) begin n_err++; $display("FAIL rmid_capture: got v=%b want 1", instrValid); end
    #3;
    rstN = 1'b0;
    #1;
    n_cmp++; if (instrValid !== 1'b0 || imemReq !== 1'b0 || opCode !== 6'd0) begin
      n_err++; $display("FAIL rmid_async: got v=%b req=%b op=%0d want v=0 req=0 op=0", instrValid, imemReq, opCode);
    end
    imemAck = 1'b1; imemData = 32'h2008_0007;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    imemAck = 1'b0;
    n_cmp++; if (imemReq !== 1'b1 || imemAddr !== RST_PC || instrValid !== 1'b0) begin
      n_err++; $display("FAIL rmid_restart: got req=%b @%h v=%b want req=1 @%h v=0", imemReq, imemAddr, instrValid, RST_PC);
    end
    @(posedge clk); #1;
    n_cmp++; if (instrValid !== 1'b0 || imemAddr !== RST_PC) begin
      n_err++; $display("FAIL rmid_no_capture: got v=%b @%h want v=0 @%h", instrValid, imemAddr, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_jump();
    test_redirect_hold();
    test_redirect_drop();
    test_redirect_jump_wrap();
    test_reset_mid();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
